// File: rtl/am_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator machine.
// Drives req/ack fetches and data accesses plus the datapath controls.
module am_seq #(
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [OPCODE_W+ADDR_W-1:0] imem_rdata,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [ADDR_W-1:0]          dmem_addr,
  input  logic                       dmem_ack,
  input  logic                       acc_zero,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [ADDR_W-1:0]          operand,
  output logic                       acc_load,
  output logic [ADDR_W-1:0]          pc,
  output logic                       busy,
  output logic                       halted,
  output logic [CNT_W-1:0]           retired
);

  localparam int IW = OPCODE_W + ADDR_W;

  localparam logic [OPCODE_W-1:0] OP_ALU_MAX = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_ST      = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP     = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JZ      = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_HALT    = OPCODE_W'(11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     ir;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] pc_inc;
  logic              ret_inc;
  logic              ir_ld;
  logic              is_mem_op;
  logic              is_st;

  assign opcode    = ir[IW-1:ADDR_W];
  assign operand   = ir[ADDR_W-1:0];
  assign imem_addr = pc;
  assign dmem_addr = operand;
  assign pc_inc    = pc + ADDR_W'(1);
  assign is_st     = (opcode == OP_ST);
  assign is_mem_op = (opcode <= OP_ALU_MAX) || is_st;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ret_inc  = 1'b0;
    ir_ld    = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    acc_load = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        busy     = 1'b1;
        state_nx = S_FETCH;
        ret_inc  = 1'b1;
        unique case (1'b1)
          is_mem_op: begin
            ret_inc  = 1'b0;
            state_nx = S_MEM;
          end
          opcode == OP_JMP: pc_nx = operand;
          opcode == OP_JZ:  pc_nx = acc_zero ? operand : pc_inc;
          opcode == OP_HALT: state_nx = S_HALT;
          default: pc_nx = pc_inc;
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) begin
          acc_load = !is_st;
          pc_nx    = pc_inc;
          ret_inc  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_nx    = '0;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (ir_ld)   ir      <= imem_rdata;
      if (ret_inc) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_am_seq.sv
// Bench for am_seq: directed literal checks, then random programs and
// random wait states against an instruction-level reference model.
module tb_am_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [11:0] imem_rdata = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic        dmem_ack = 1'b0;
  logic        acc_zero = 1'b0;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        acc_load;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  am_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_ack(dmem_ack), .acc_zero(acc_zero),
    .opcode(opcode), .operand(operand), .acc_load(acc_load),
    .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  logic [11:0] imem [256];

  // Reference model: where the instruction is in its life, plus the
  // architectural pc / instruction / retired count.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_MEM = 3, PH_HALT = 4;
  int          ph = PH_IDLE;
  logic [7:0]  m_pc = '0;
  logic [11:0] m_ir = '0;
  logic [15:0] m_ret = '0;

  always @(negedge clk) imem_rdata <= imem[m_pc];

  always @(posedge clk) begin
    logic [3:0] op;
    op = m_ir[11:8];
    if (rst) begin
      ph = PH_IDLE; m_pc = '0; m_ir = '0; m_ret = '0;
    end else if (ph == PH_IDLE) begin
      if (start) ph = PH_FETCH;
    end else if (ph == PH_FETCH) begin
      if (imem_ack) begin m_ir = imem_rdata; ph = PH_DEC; end
    end else if (ph == PH_DEC) begin
      if (op <= 4'h8) ph = PH_MEM;
      else begin
        m_ret = m_ret + 16'd1;
        ph = PH_FETCH;
        if (op == 4'h9) m_pc = m_ir[7:0];
        else if (op == 4'hA) m_pc = acc_zero ? m_ir[7:0] : m_pc + 8'd1;
        else if (op == 4'hB) ph = PH_HALT;
        else m_pc = m_pc + 8'd1;
      end
    end else if (ph == PH_MEM) begin
      if (dmem_ack) begin
        m_pc = m_pc + 8'd1; m_ret = m_ret + 16'd1; ph = PH_FETCH;
      end
    end else begin
      if (start) begin m_pc = '0; ph = PH_FETCH; end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic mem;
      mem = (ph == PH_MEM);
      chk("imem_req", imem_req, ph == PH_FETCH);
      chk("imem_addr", imem_addr, m_pc);
      chk("dmem_req", dmem_req, mem);
      chk("dmem_we", dmem_we, mem && m_ir[11:8] == 4'h8);
      chk("dmem_addr", dmem_addr, m_ir[7:0]);
      chk("acc_load", acc_load, mem && dmem_ack && m_ir[11:8] != 4'h8);
      chk("opcode", opcode, m_ir[11:8]);
      chk("operand", operand, m_ir[7:0]);
      chk("pc", pc, m_pc);
      chk("busy", busy, ph == PH_FETCH || ph == PH_DEC || ph == PH_MEM);
      chk("halted", halted, ph == PH_HALT);
      chk("retired", retired, m_ret);
      chk("req_excl", imem_req & dmem_req, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 12'hC00;
    imem[8'h00] = 12'h010;
    imem[8'h01] = 12'hA40;
    imem[8'h40] = 12'hB00;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    acc_zero = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_retired", retired, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ireq", imem_req, 1'b0);

    start = 1'b1; step(); start = 1'b0;
    @(negedge clk);
    chk("c1_ireq", imem_req, 1'b1);
    chk("c1_iaddr", imem_addr, 8'h00);
    start = 1'b1;
    step();
    @(negedge clk);
    chk("c2_opcode", opcode, 4'h0);
    chk("c2_operand", operand, 8'h10);
    chk("c2_dreq", dmem_req, 1'b0);
    step(); start = 1'b0;
    @(negedge clk);
    chk("c3_dreq", dmem_req, 1'b1);
    chk("c3_daddr", dmem_addr, 8'h10);
    chk("c3_we", dmem_we, 1'b0);
    chk("c3_accld", acc_load, 1'b1);
    step();
    @(negedge clk);
    chk("alu_pc", pc, 8'h01);
    chk("alu_ret", retired, 16'd1);
    step(); step();
    @(negedge clk);
    chk("jz_pc", pc, 8'h40);
    chk("jz_ret", retired, 16'd2);
    step(); step();
    @(negedge clk);
    chk("halt_h", halted, 1'b1);
    chk("halt_busy", busy, 1'b0);
    chk("halt_pc", pc, 8'h40);
    step();
    @(negedge clk);
    chk("halt_frozen", pc, 8'h40);
    start = 1'b1; step(); start = 1'b0;
    @(negedge clk);
    chk("restart_pc", pc, 8'h00);
    chk("restart_ireq", imem_req, 1'b1);

    // Reset in the middle of a data access, then a stale ack.
    dmem_ack = 1'b0;
    step(); step();
    @(negedge clk);
    chk("mem_dreq", dmem_req, 1'b1);
    rst = 1'b1; step(); rst = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    chk("rst_mid_dreq", dmem_req, 1'b0);
    chk("rst_mid_accld", acc_load, 1'b0);
    chk("rst_mid_op", operand, 8'h00);
    step();
    @(negedge clk);
    chk("stale_busy", busy, 1'b0);

    // JMP to 0xFF then NOP wraps pc.
    imem[8'h00] = 12'h9FF;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    @(negedge clk);
    chk("jmp_iaddr", imem_addr, 8'hFF);
    step(); step();
    @(negedge clk);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_ret", retired, 16'd2);

    // Random programs with random wait states and stray inputs.
    for (int i = 0; i < 256; i++) imem[i] = 12'($urandom);
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      start    = ($urandom_range(0, 9) == 0);
      imem_ack = ($urandom_range(0, 2) == 0);
      dmem_ack = ($urandom_range(0, 3) == 0);
      acc_zero = $urandom_range(0, 1) == 1;
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
